// File: rtl/clock_pkg.sv
// Shared encodings for the desktop-clock mode sequencer: state codes,
// display-source codes and default alarm timing.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SET_TIME  = 3'd1,
    ST_SET_ALARM = 3'd2,
    ST_RING      = 3'd3,
    ST_SNOOZE    = 3'd4
  } mode_e;

  localparam logic [1:0] DISP_TIME = 2'd0;
  localparam logic [1:0] DISP_TSET = 2'd1;
  localparam logic [1:0] DISP_ASET = 2'd2;
  localparam logic [1:0] DISP_RING = 2'd3;

  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 300;

  // Snooze deliberately shows the time, not the ring pattern.
  function automatic logic [1:0] disp_of(mode_e m);
    case (m)
      ST_SET_TIME:  disp_of = DISP_TSET;
      ST_SET_ALARM: disp_of = DISP_ASET;
      ST_RING:      disp_of = DISP_RING;
      default:      disp_of = DISP_TIME;
    endcase
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter; holds at zero instead of wrapping.
module sec_countdown #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                 cnt_d = load_val;
    else if (tick && !zero)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the desktop clock: owns button routing, setter
// clear/commit strobes, and the ring/snooze timing.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int CNT_W      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       ent,
  input  logic       ret,
  input  logic       bstep,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  input  logic       time_done,
  input  logic       alarm_done,
  input  logic       alarm_match,
  output logic       ent_t,
  output logic       ret_t,
  output logic       bstep_t,
  output logic       ent_a,
  output logic       ret_a,
  output logic       bstep_a,
  output logic       clr_t,
  output logic       clr_a,
  output logic       load_time,
  output logic       load_alarm,
  output logic       alarm_armed,
  output logic       alarm_going_off,
  output logic [1:0] disp_sel,
  output logic [2:0] mode
);

  mode_e state_q, state_d;
  logic  pend_q, pend_d, armed_q, armed_d;
  logic  am_q, td_q, ad_q;
  logic  load_t_q, load_t_d, load_a_q, load_a_d;
  logic  clr_t_q, clr_t_d, clr_a_q, clr_a_d;
  logic  [1:0] disp_q;
  logic  ring_q;
  logic  am_rise, td_rise, ad_rise;
  logic  cd_load, cd_tick, cd_zero;
  logic  [CNT_W-1:0] cd_val;

  assign am_rise = alarm_match & ~am_q;
  assign td_rise = time_done   & ~td_q;
  assign ad_rise = alarm_done  & ~ad_q;
  assign cd_tick = sec_tick & (state_q == ST_RING || state_q == ST_SNOOZE);

  sec_countdown #(.CNT_W(CNT_W)) u_cd (
    .clk      (clk),
    .rst      (rst),
    .load     (cd_load),
    .load_val (cd_val),
    .tick     (cd_tick),
    .zero     (cd_zero)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    armed_d  = armed_q;
    load_t_d = 1'b0;
    load_a_d = 1'b0;
    clr_t_d  = 1'b0;
    clr_a_d  = 1'b0;
    cd_load  = 1'b0;
    cd_val   = '0;
    case (state_q)
      ST_RUN: begin
        // A due alarm beats a simultaneous mode press.
        if (armed_q && (am_rise || pend_q)) begin
          state_d = ST_RING;
          pend_d  = 1'b0;
          cd_load = 1'b1;
          cd_val  = CNT_W'(RING_SEC);
        end else if (btn_mode) begin
          state_d = ST_SET_TIME;
          clr_t_d = 1'b1;
        end
      end
      ST_SET_TIME: begin
        if (armed_q && am_rise) pend_d = 1'b1;
        if (td_rise) begin
          state_d  = ST_RUN;
          load_t_d = 1'b1;
        end else if (btn_mode) begin
          state_d = ST_SET_ALARM;
          clr_a_d = 1'b1;
        end
      end
      ST_SET_ALARM: begin
        if (armed_q && am_rise) pend_d = 1'b1;
        if (ad_rise) begin
          state_d  = ST_RUN;
          load_a_d = 1'b1;
          armed_d  = 1'b1;
        end else if (btn_mode) begin
          state_d = ST_RUN;
        end
      end
      ST_RING: begin
        if (btn_stop) begin
          state_d = ST_RUN;
        end else if (btn_snooze) begin
          state_d = ST_SNOOZE;
          cd_load = 1'b1;
          cd_val  = CNT_W'(SNOOZE_SEC);
        end else if (cd_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_SNOOZE: begin
        if (btn_stop) begin
          state_d = ST_RUN;
        end else if (cd_zero) begin
          state_d = ST_RING;
          cd_load = 1'b1;
          cd_val  = CNT_W'(RING_SEC);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pend_q   <= 1'b0;
      armed_q  <= 1'b0;
      am_q     <= 1'b0;
      td_q     <= 1'b0;
      ad_q     <= 1'b0;
      load_t_q <= 1'b0;
      load_a_q <= 1'b0;
      clr_t_q  <= 1'b0;
      clr_a_q  <= 1'b0;
      disp_q   <= DISP_TIME;
      ring_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      armed_q  <= armed_d;
      am_q     <= alarm_match;
      td_q     <= time_done;
      ad_q     <= alarm_done;
      load_t_q <= load_t_d;
      load_a_q <= load_a_d;
      clr_t_q  <= clr_t_d;
      clr_a_q  <= clr_a_d;
      disp_q   <= disp_of(state_d);
      ring_q   <= (state_d == ST_RING);
    end
  end

  assign ent_t   = ent   & (state_q == ST_SET_TIME);
  assign ret_t   = ret   & (state_q == ST_SET_TIME);
  assign bstep_t = bstep & (state_q == ST_SET_TIME);
  assign ent_a   = ent   & (state_q == ST_SET_ALARM);
  assign ret_a   = ret   & (state_q == ST_SET_ALARM);
  assign bstep_a = bstep & (state_q == ST_SET_ALARM);

  assign clr_t           = clr_t_q;
  assign clr_a           = clr_a_q;
  assign load_time       = load_t_q;
  assign load_alarm      = load_a_q;
  assign alarm_armed     = armed_q;
  assign alarm_going_off = ring_q;
  assign disp_sel        = disp_q;
  assign mode            = state_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with a cycle-level reference model
// checked every falling edge, plus literal spot checks along the way.
module tb_clock_mode_ctrl;

  localparam int RS = 60;
  localparam int SS = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic sec_tick = 0, btn_mode = 0, ent = 0, ret = 0, bstep = 0;
  logic btn_stop = 0, btn_snooze = 0;
  logic time_done = 0, alarm_done = 0, alarm_match = 0;
  logic ent_t, ret_t, bstep_t, ent_a, ret_a, bstep_a;
  logic clr_t, clr_a, load_time, load_alarm, alarm_armed, alarm_going_off;
  logic [1:0] disp_sel;
  logic [2:0] mode;

  clock_mode_ctrl #(.RING_SEC(RS), .SNOOZE_SEC(SS), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .btn_mode(btn_mode),
    .ent(ent), .ret(ret), .bstep(bstep), .btn_stop(btn_stop),
    .btn_snooze(btn_snooze), .time_done(time_done), .alarm_done(alarm_done),
    .alarm_match(alarm_match), .ent_t(ent_t), .ret_t(ret_t), .bstep_t(bstep_t),
    .ent_a(ent_a), .ret_a(ret_a), .bstep_a(bstep_a), .clr_t(clr_t),
    .clr_a(clr_a), .load_time(load_time), .load_alarm(load_alarm),
    .alarm_armed(alarm_armed), .alarm_going_off(alarm_going_off),
    .disp_sel(disp_sel), .mode(mode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Reference model: state 0..4, seconds left, and the flags the rules name.
  int m_st = 0, m_cnt = 0;
  bit m_armed = 0, m_pend = 0, m_amp = 0, m_tdp = 0, m_adp = 0;
  bit m_lt = 0, m_la = 0, m_ct = 0, m_ca = 0;
  wire m_ram = alarm_match & ~m_amp;
  wire m_rtd = time_done & ~m_tdp;
  wire m_rad = alarm_done & ~m_adp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0; m_armed <= 0; m_pend <= 0;
      m_amp <= 0; m_tdp <= 0; m_adp <= 0;
      m_lt <= 0; m_la <= 0; m_ct <= 0; m_ca <= 0;
    end else begin
      m_amp <= alarm_match; m_tdp <= time_done; m_adp <= alarm_done;
      m_lt <= 0; m_la <= 0; m_ct <= 0; m_ca <= 0;
      case (m_st)
        0: if (m_armed && (m_ram || m_pend)) begin
             m_st <= 3; m_cnt <= RS; m_pend <= 0;
           end else if (btn_mode) begin
             m_st <= 1; m_ct <= 1;
           end
        1: begin
             if (m_armed && m_ram) m_pend <= 1;
             if (m_rtd) begin m_st <= 0; m_lt <= 1; end
             else if (btn_mode) begin m_st <= 2; m_ca <= 1; end
           end
        2: begin
             if (m_armed && m_ram) m_pend <= 1;
             if (m_rad) begin m_st <= 0; m_la <= 1; m_armed <= 1; end
             else if (btn_mode) m_st <= 0;
           end
        3: if (btn_stop) m_st <= 0;
           else if (btn_snooze) begin m_st <= 4; m_cnt <= SS; end
           else if (m_cnt == 0) m_st <= 0;
           else if (sec_tick) m_cnt <= m_cnt - 1;
        4: if (btn_stop) m_st <= 0;
           else if (m_cnt == 0) begin m_st <= 3; m_cnt <= RS; end
           else if (sec_tick) m_cnt <= m_cnt - 1;
        default: m_st <= 0;
      endcase
    end
  end

  function automatic logic [1:0] exp_disp(int s);
    return (s == 1) ? 2'd1 : (s == 2) ? 2'd2 : (s == 3) ? 2'd3 : 2'd0;
  endfunction

  logic [16:0] exp_v, act_v;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = {3'(m_st), exp_disp(m_st), 1'(m_st == 3), m_armed, m_lt, m_la,
               m_ct, m_ca, ent & (m_st == 1), ret & (m_st == 1),
               bstep & (m_st == 1), ent & (m_st == 2), ret & (m_st == 2),
               bstep & (m_st == 2)};
      act_v = {mode, disp_sel, alarm_going_off, alarm_armed, load_time,
               load_alarm, clr_t, clr_a, ent_t, ret_t, bstep_t, ent_a, ret_a,
               bstep_a};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL model t=%0t got=%h want=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Advance one clock; pulse inputs last exactly one cycle.
  task automatic step();
    @(posedge clk); #1;
    sec_tick = 0; btn_mode = 0; ent = 0; ret = 0; bstep = 0;
    btn_stop = 0; btn_snooze = 0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_disp", disp_sel, 0);
    chk("rst_armed", alarm_armed, 0);
    chk("rst_ring", alarm_going_off, 0);
    rst = 1'b0; chk_en = 1;
    step(); step();

    // Set time and commit
    btn_mode = 1; step();
    chk("st_clr_t", clr_t, 1); chk("st_mode", mode, 1); chk("st_disp", disp_sel, 1);
    step();
    chk("st_clr_t_off", clr_t, 0);
    ent = 1; #1;
    chk("st_ent_t", ent_t, 1); chk("st_ent_a", ent_a, 0);
    step();
    time_done = 1; step();
    chk("st_load", load_time, 1); chk("st_back_run", mode, 0);
    step();
    chk("st_load_once", load_time, 0);
    time_done = 0; step();

    // Abort through both set modes
    btn_mode = 1; step(); chk("ab_m1", mode, 1);
    btn_mode = 1; step(); chk("ab_m2", mode, 2); chk("ab_clr_a", clr_a, 1);
    btn_mode = 1; step(); chk("ab_m0", mode, 0);
    chk("ab_noload", load_alarm, 0); chk("ab_unarmed", alarm_armed, 0);

    // Commit an alarm
    btn_mode = 1; step(); btn_mode = 1; step();
    alarm_done = 1; step();
    chk("al_load", load_alarm, 1); chk("al_armed", alarm_armed, 1);
    alarm_done = 0; step();

    // Ring with auto-stop after RS ticks
    alarm_match = 1; step();
    chk("rg_on", alarm_going_off, 1); chk("rg_mode", mode, 3); chk("rg_disp", disp_sel, 3);
    for (int i = 0; i < RS; i++) begin
      sec_tick = 1; step();
      if (i == RS - 2) chk("rg_still", mode, 3);
    end
    step();
    chk("rg_auto_stop", mode, 0); chk("rg_off", alarm_going_off, 0);
    repeat (3) step();
    chk("rg_no_retrig", mode, 0);
    alarm_match = 0; step();

    // Snooze then stop
    alarm_match = 1; step(); chk("sz_ring", mode, 3);
    btn_snooze = 1; step();
    chk("sz_mode", mode, 4); chk("sz_quiet", alarm_going_off, 0); chk("sz_disp", disp_sel, 0);
    alarm_match = 0;
    for (int i = 0; i < SS; i++) begin sec_tick = 1; step(); end
    step();
    chk("sz_rering", mode, 3);
    btn_stop = 1; step();
    chk("sz_stop", mode, 0); chk("sz_armed", alarm_armed, 1);

    // Alarm edge while setting time becomes pending
    btn_mode = 1; step(); chk("pd_set", mode, 1);
    alarm_match = 1; step(); chk("pd_hold", mode, 1);
    time_done = 1; step();
    chk("pd_load", load_time, 1); chk("pd_run", mode, 0);
    step();
    chk("pd_ring", mode, 3);
    time_done = 0; alarm_match = 0;
    btn_stop = 1; btn_snooze = 1; step();
    chk("pr_stop_wins", mode, 0);
    step();
    alarm_match = 1; btn_mode = 1; step();
    chk("pr_alarm_wins", mode, 3); chk("pr_no_clr", clr_t, 0);

    // Asynchronous reset mid-ring
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("ar_mode", mode, 0); chk("ar_disp", disp_sel, 0);
    chk("ar_ring", alarm_going_off, 0); chk("ar_armed", alarm_armed, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(); step();
    chk("ar_stays_run", mode, 0);
    alarm_match = 0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
